// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag-index and FSM-state definitions for the EX-stage ALU.
package alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: radix-2 shift-add multiplier, one bit of b per cycle; done is asserted
// during the final iteration with product already holding the completed low WIDTH bits.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    assign product = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy    = r_busy;
    assign done    = r_busy && r_cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH);
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            r_busy   <= r_cnt != CW'(1);
        end
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: EX-stage ALU with valid/ready handshake and registered result/NZCV flags.
// Define ALU_MUL_EN to compile in the iterative multiplier (code 1000); otherwise 1000 is illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       flags,
    output logic             illegal
);
    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [3:0]       r_flags;
    logic             r_illegal;

    logic             w_accept;
    logic             w_legal;
    logic             w_sub;
    logic             w_arith;
    logic             w_in_mul;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_ld_res;
    logic [3:0]       w_ld_flags;
    logic             w_mul_go;
    logic             w_mul_load;

    assign in_ready  = r_state == ST_IDLE && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign flags     = r_flags;
    assign illegal   = r_illegal;

`ifdef ALU_MUL_EN
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;

    assign w_legal    = code inside {ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_MUL};
    assign w_in_mul   = r_state == ST_MUL;
    assign w_mul_go   = w_accept && code == ALU_MUL;
    assign w_mul_load = w_in_mul && w_mul_done;
    assign w_ld_res   = w_in_mul ? w_mul_prod : w_res;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_go),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );
`else
    assign w_legal    = code inside {ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB};
    assign w_in_mul   = 1'b0;
    assign w_mul_go   = 1'b0;
    assign w_mul_load = 1'b0;
    assign w_ld_res   = w_res;
`endif

    // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        w_sub   = code == ALU_SUB;
        w_arith = w_sub || code == ALU_ADD;
        w_bx    = w_sub ? ~b : b;
        w_sum   = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
        w_res   = code == ALU_AND   ? a & b :
                  code == ALU_ORR   ? a | b :
                  w_arith           ? w_sum[WIDTH-1:0] :
                  code == ALU_PASSB ? b : '0;
        w_ld_flags         = '0;
        w_ld_flags[FLAG_N] = w_ld_res[WIDTH-1];
        w_ld_flags[FLAG_Z] = w_ld_res == '0;
        w_ld_flags[FLAG_C] = !w_in_mul && w_arith && w_sum[WIDTH];
        w_ld_flags[FLAG_V] = !w_in_mul && w_arith && a[WIDTH-1] == w_bx[WIDTH-1] && w_sum[WIDTH-1] != a[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_flags     <= '0;
            r_illegal   <= 1'b0;
        end else if (w_mul_load || (w_accept && !w_mul_go)) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
            r_result    <= w_ld_res;
            r_zero      <= w_ld_flags[FLAG_Z];
            r_flags     <= w_ld_flags;
            r_illegal   <= !w_in_mul && !w_legal;
        end else if (w_mul_go) begin
            r_state     <= ST_MUL;
            r_out_valid <= 1'b0;
        end else begin
`ifdef ALU_MUL_EN
            if (w_in_mul && !w_mul_busy)
                r_state <= ST_IDLE;
`endif
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against an arithmetic reference model.
// Honours ALU_MUL_EN the same way the design does.
module tb_alu_exec;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic [3:0]   flags;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         ill;
        int           lat;
    } exp_t;

    exp_t q[$];

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        logic   cy = 1'b0;
        logic   ov = 1'b0;
        longint sx = longint'(x);
        longint sy = longint'(y);
        longint sr;
        e.ill = 1'b0;
        e.lat = 1;
        case (c)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: begin
                e.res = x + y;
                cy = ({1'b0, x} + {1'b0, y}) > {1'b0, {W{1'b1}}};
                sr = longint'(e.res);
                ov = (sx >= 0 && sy >= 0 && sr < 0) || (sx < 0 && sy < 0 && sr >= 0);
            end
            4'b0110: begin
                e.res = x - y;
                cy = x >= y;
                sr = longint'(e.res);
                ov = (sx >= 0 && sy < 0 && sr < 0) || (sx < 0 && sy >= 0 && sr >= 0);
            end
            4'b0111: e.res = y;
`ifdef ALU_MUL_EN
            4'b1000: begin
                e.res = x * y;
                e.lat = W + 1;
            end
`endif
            default: begin
                e.res = '0;
                e.ill = 1'b1;
            end
        endcase
        e.fl = {e.res[W-1], e.res == '0, cy, ov};
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            4: return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e = model(c, x, y);
        int   n = 0;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_rdy"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        code = c;
        a = x;
        b = y;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, W'(n), W'(e.lat));
        chk({tag, "_res"}, result, e.res);
        chk({tag, "_flags"}, W'(flags), W'(e.fl));
        chk({tag, "_zero"}, W'(zero), W'(e.fl[2]));
        chk({tag, "_ill"}, W'(illegal), W'(e.ill));
    endtask

    initial begin
        logic [W-1:0] held_res;
        logic [3:0]   held_fl;
        logic         held_ill;
        logic         prev_hold;
        logic         seen;
        logic [3:0]   stream_codes[6];
        logic [3:0]   rnd_codes[10];
        exp_t         e;
        int           n;

        stream_codes = '{4'b0001, 4'b0000, 4'b0111, 4'b0001, 4'b0111, 4'b0000};
        rnd_codes    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0010, 4'b0110, 4'b0011, 4'b1111, 4'b1000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        code = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), W'(0));
        chk("rst_flags", W'(flags), W'(0));
        chk("rst_illegal", W'(illegal), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));

        run_op("add5_7", 4'b0010, 64'd5, 64'd7);
        chk("add5_7_const", result, 64'd12);
        run_op("sub3_3", 4'b0110, 64'd3, 64'd3);
        chk("sub3_3_flags", W'(flags), W'(4'b0110));
        run_op("sub0_1", 4'b0110, 64'd0, 64'd1);
        chk("sub0_1_flags", W'(flags), W'(4'b1000));
        run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_ovf_flags", W'(flags), W'(4'b1001));
        run_op("ill_0011", 4'b0011, 64'd9, 64'd4);
        chk("ill_0011_const", W'({illegal, zero, flags}), W'(6'b110100));
        run_op("code_1000", 4'b1000, 64'd6, 64'd7);
        run_op("after_ill", 4'b0001, 64'hF0, 64'h0F);

        // Back-to-back stream: one result per cycle, in order
        out_ready = 1'b1;
        foreach (stream_codes[i]) begin
            logic [W-1:0] x = rnd_val();
            logic [W-1:0] y = rnd_val();
            e = model(stream_codes[i], x, y);
            in_valid = 1'b1;
            code = stream_codes[i];
            a = x;
            b = y;
            #1;
            chk("stream_rdy", W'(in_ready), W'(1));
            step();
            chk("stream_valid", W'(out_valid), W'(1));
            chk("stream_res", result, e.res);
        end
        in_valid = 1'b0;
        step();

        run_op("bp_orr", 4'b0001, 64'h1234, 64'h8000_0000_0000_0000);
        out_ready = 1'b0;
        held_res = result;
        held_fl = flags;
        repeat (3) begin
            step();
            chk("bp_valid", W'(out_valid), W'(1));
            chk("bp_res", result, held_res);
            chk("bp_flags", W'(flags), W'(held_fl));
            chk("bp_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        step();
        chk("bp_released", W'(out_valid), W'(0));

`ifdef ALU_MUL_EN
        run_op("mul6_7", 4'b1000, 64'd6, 64'd7);
        chk("mul6_7_const", result, 64'd42);
        step();
        in_valid = 1'b1;
        code = 4'b1000;
        a = 64'd6;
        b = 64'd7;
        step();
        in_valid = 1'b0;
        repeat (19) step();
        chk("mul_busy_rdy", W'(in_ready), W'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mulrst_valid", W'(out_valid), W'(0));
        chk("mulrst_rdy", W'(in_ready), W'(1));
        seen = 1'b0;
        repeat (70) begin
            step();
            if (out_valid)
                seen = 1'b1;
        end
        chk("mulrst_nores", W'(seen), W'(0));
`endif

        // Randomized traffic with random backpressure against a scoreboard
        prev_hold = 1'b0;
        held_ill = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (prev_hold) begin
                chk("rnd_hold_res", result, held_res);
                chk("rnd_hold_flags", W'(flags), W'(held_fl));
                chk("rnd_hold_ill", W'(illegal), W'(held_ill));
            end
            out_ready = $urandom_range(0, 3) != 0;
            in_valid = $urandom_range(0, 2) != 0;
            code = rnd_codes[$urandom_range(0, 9)];
            a = rnd_val();
            b = rnd_val();
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", W'(1), W'(0));
                end else begin
                    e = q.pop_front();
                    chk("rnd_res", result, e.res);
                    chk("rnd_flags", W'(flags), W'(e.fl));
                    chk("rnd_ill", W'(illegal), W'(e.ill));
                end
            end
            if (out_valid && !out_ready)
                chk("rnd_bp_rdy", W'(in_ready), W'(0));
            prev_hold = out_valid && !out_ready;
            held_res = result;
            held_fl = flags;
            held_ill = illegal;
            if (in_valid && in_ready)
                q.push_back(model(code, a, b));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        #1;
        while (q.size() != 0 && n < 200) begin
            if (out_valid) begin
                e = q.pop_front();
                chk("drain_res", result, e.res);
                chk("drain_flags", W'(flags), W'(e.fl));
            end
            step();
            #1;
            n++;
        end
        chk("drain_empty", W'(q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
# alu_exec

Sequential execute unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two operands. It returns a registered result, a zero indication and NZCV flags over a valid/ready handshake. It sits in the EX stage of the LEGv8 datapath, between the register-read/ALU-control stage and memory/write-back. It supports single-cycle logic and arithmetic ops and an optional iterative multiply.

## Interface
- WIDTH, 64, operand and result width in bits (≥ 8)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation request present
- in_ready  out  1  unit can accept a request this cycle
- code  in  4  ALU operation code (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream consumes result this cycle
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- flags  out  4  {N, Z, C, V}
- illegal  out  1  accepted code was not a supported operation

## Operation
- Codes: 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (a − b); 0111 PASS_B (result = b, used for CBZ); 1000 MUL (low WIDTH bits of a × b, only with ALU_MUL_EN). Any other code is illegal.
- Accept happens on a cycle with in_valid && in_ready. Operands and code are captured at accept.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational and involves no dependency of in_ready on in_valid.
- FSM states:
  - IDLE: on accept of a single-cycle op, load the result register and stay in IDLE. On accept of MUL, go to MUL.
  - MUL: radix-2 shift-add, one bit of b per cycle, WIDTH iterations. After the last iteration, load the result register and return to IDLE.
- Flag rules:
  - N = result[WIDTH-1]; Z = zero.
  - ADD: C is the carry-out; V is signed overflow.
  - SUB: computed as a + ~b + 1. C = 1 when a ≥ b unsigned (no borrow); V is signed overflow.
  - AND, ORR, PASS_B, MUL: C = V = 0.
- Illegal code: result = 0, flags = {0,1,0,0}, illegal = 1, latency 1. The illegal output is cleared by the next loaded result.
- All arithmetic is modulo 2^WIDTH; overflow bits beyond WIDTH are discarded.

## Timing
- Reset values: out_valid=0, result=0, zero=0, flags=0, illegal=0, state=IDLE. in_ready=1 in the cycle after reset deasserts.
- Single-cycle ops: out_valid asserts the cycle after accept (latency 1). Back-to-back throughput is 1 op per cycle while out_ready=1.
- MUL: out_valid asserts WIDTH+1 cycles after accept. in_ready=0 throughout the MUL state.
- Backpressure: while out_valid && !out_ready, result, zero, flags and illegal must be held stable, and in_ready=0.
- Simultaneous consume and accept (out_valid && out_ready && in_valid && single-cycle op): the new result replaces the old one in the same edge, and out_valid stays 1.
- rst asserted mid-MUL: the multiply is aborted and the reset values apply the next cycle. No result is produced.

## Configuration
- ALU_MUL_EN:
  - Defined: MUL state and the multiplier are compiled in; code 1000 is legal.
  - Undefined: no MUL state or multiplier hardware; code 1000 is treated as illegal with latency 1.

## Structure
- Package alu_pkg holds:
  - code constants ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_MUL;
  - flag bit index constants FLAG_N, FLAG_Z, FLAG_C, FLAG_V;
  - the FSM state enum.
- Sub-module alu_mul_seq (start/busy/done, WIDTH parameter) implements the iterative multiplier. It is instantiated only under ALU_MUL_EN.

## Test plan
- Reset then ADD a=5, b=7 → next cycle out_valid=1, result=12, flags=0000.
- SUB a=3, b=3 → result=0, zero=1, flags={0,1,1,0}. SUB a=0, b=1 → result=all ones, flags={1,0,0,0}.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → result=0x8000_0000_0000_0000, N=1, V=1, C=0.
- Streaming ORR/AND/PASS_B with out_ready=1 each cycle → one result per cycle, in order. Drop out_ready for 3 cycles → outputs held stable and in_ready=0.
- MUL a=6, b=7 (ALU_MUL_EN) → result=42 exactly 65 cycles after accept. Assert rst at cycle 20 → no out_valid, and in_ready=1 after reset.
- code=0011 → illegal=1, result=0, zero=1. Same test with code=1000 and ALU_MUL_EN undefined → identical response.
